// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: single-cycle logic/arithmetic ops, iterative one-bit-per-cycle shifter.
module alu_exec_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Operacioni,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Rezultati,
   output logic             Zero,
   output logic             Overflow,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned SHW = 4;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic             dir_right;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] imm_res;
   logic             imm_ovf;
   logic [WIDTH-1:0] acc_next;
   logic [SHW-1:0]   shamt;
   logic             is_shift;

   assign shamt    = B[SHW-1:0];
   assign is_shift = (Operacioni == OP_SLL) || (Operacioni == OP_SRL);

   // Immediate result and overflow for ops that complete at the accepting edge.
   always_comb begin
      imm_res = '0;
      imm_ovf = 1'b0;
      sum     = A + B;
      diff    = A - B;
      case (Operacioni)
         OP_AND: imm_res = A & B;
         OP_OR:  imm_res = A | B;
         OP_ADD: begin
            imm_res = sum;
            imm_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_XOR: imm_res = A ^ B;
         OP_SLL: imm_res = A;   // only reached with a zero shift amount
         OP_SRL: imm_res = A;
         OP_SUB: begin
            imm_res = diff;
            imm_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SLT: imm_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : WIDTH'(0);
         default: imm_res = '0;
      endcase
   end

   // One-bit shift step of the accumulator in the latched direction.
   always_comb begin
      acc_next = dir_right ? (acc >> 1) : (acc << 1);
   end

   // Control FSM with registered result, flags and handshake outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         dir_right <= 1'b0;
         Rezultati <= '0;
         Zero      <= 1'b0;
         Overflow  <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  if (is_shift && (shamt != '0)) begin
                     acc       <= A;
                     cnt       <= shamt;
                     dir_right <= Operacioni[0];
                     state     <= SHIFT;
                     Busy      <= 1'b1;
                     Done      <= 1'b0;
                  end else begin
                     Rezultati <= imm_res;
                     Zero      <= (imm_res == '0);
                     Overflow  <= imm_ovf;
                     state     <= DONE;
                     Busy      <= 1'b0;
                     Done      <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  Busy  <= 1'b0;
                  Done  <= 1'b0;
               end
            end
            SHIFT: begin
               acc <= acc_next;
               cnt <= cnt - SHW'(1);
               // last step: publish the shifted value directly
               if (cnt == SHW'(1)) begin
                  Rezultati <= acc_next;
                  Zero      <= (acc_next == '0);
                  Overflow  <= 1'b0;
                  state     <= DONE;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops against an arithmetic model.
module tb_alu_exec_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [2:0]  Operacioni;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] Rezultati;
   logic        Zero;
   logic        Overflow;
   logic        Busy;
   logic        Done;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] hold_res;
   logic        hold_z;
   logic        hold_o;

   alu_exec_unit #(.WIDTH(16)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Operacioni(Operacioni),
      .A(A), .B(B), .Rezultati(Rezultati), .Zero(Zero), .Overflow(Overflow),
      .Busy(Busy), .Done(Done)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operation table.
   function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic ovf);
      int sa;
      int sb;
      int s;
      int sh;
      sa  = $signed(a);
      sb  = $signed(b);
      sh  = int'(b % 16'd16);
      ovf = 1'b0;
      r   = 16'h0000;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin s = sa + sb; r = 16'(s); ovf = (s > 32767) || (s < -32768); end
         3'd3: r = a ^ b;
         3'd4: r = 16'(32'(a) * (32'd1 << sh));
         3'd5: r = 16'(32'(a) / (32'd1 << sh));
         3'd6: begin s = sa - sb; r = 16'(s); ovf = (s > 32767) || (s < -32768); end
         default: r = (sa < sb) ? 16'h0001 : 16'h0000;
      endcase
   endfunction

   // Issue one op from idle, follow it to completion and back to idle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] er;
      logic        eo;
      int          n;
      model(op, a, b, er, eo);
      n = (op == 3'd4 || op == 3'd5) ? int'(b % 16'd16) : 0;
      Operacioni = op; A = a; B = b; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < n; i++) begin
         check({tag, "_busy"}, 16'(Busy), 16'd1);
         check({tag, "_nodone"}, 16'(Done), 16'd0);
         check({tag, "_hold"}, Rezultati, hold_res);
         check({tag, "_holdflags"}, 16'({hold_z, hold_o}), 16'({Zero, Overflow}));
         // inputs wiggle during the shift; they must be ignored
         Operacioni = 3'($urandom); A = 16'($urandom); B = 16'($urandom);
         tick();
      end
      check({tag, "_done"}, 16'(Done), 16'd1);
      check({tag, "_busy0"}, 16'(Busy), 16'd0);
      check({tag, "_res"}, Rezultati, er);
      check({tag, "_zero"}, 16'(Zero), 16'(er == 16'h0000));
      check({tag, "_ovf"}, 16'(Overflow), 16'(eo));
      hold_res = er; hold_z = (er == 16'h0000); hold_o = eo;
      tick();
      check({tag, "_pulse"}, 16'(Done), 16'd0);
   endtask

   initial begin
      int          dones;
      logic [15:0] seen;
      logic [2:0]  rop;
      Reset = 1'b1; Start = 1'b0; Operacioni = 3'd0; A = '0; B = '0;
      tick();
      tick();
      check("rst_res", Rezultati, 16'h0000);
      check("rst_flags", 16'({Zero, Overflow, Busy, Done}), 16'd0);
      Reset = 1'b0;
      hold_res = 16'h0000; hold_z = 1'b0; hold_o = 1'b0;
      tick();

      run_op("add_ovf", 3'd2, 16'h7FFF, 16'h0001);
      run_op("sub_zero", 3'd6, 16'h0005, 16'h0005);
      run_op("sub_ovf", 3'd6, 16'h8000, 16'h0001);
      run_op("sll15", 3'd4, 16'h0001, 16'h000F);
      run_op("srl0", 3'd5, 16'h8000, 16'h0000);
      run_op("srl4", 3'd5, 16'h8000, 16'h0004);
      run_op("and", 3'd0, 16'hF0F0, 16'h3C3C);

      // back-to-back SUB then SLT with Start held high
      Operacioni = 3'd6; A = 16'h0005; B = 16'h0005; Start = 1'b1;
      tick();
      check("b2b_sub_done", 16'(Done), 16'd1);
      check("b2b_sub_res", Rezultati, 16'h0000);
      check("b2b_sub_zero", 16'(Zero), 16'd1);
      Operacioni = 3'd7; A = 16'hFFFF; B = 16'h0001;
      tick();
      Start = 1'b0;
      check("b2b_slt_done", 16'(Done), 16'd1);
      check("b2b_slt_res", Rezultati, 16'h0001);
      check("b2b_slt_zero", 16'(Zero), 16'd0);
      tick();
      check("b2b_pulse", 16'(Done), 16'd0);

      // Start during SHIFT is ignored
      Operacioni = 3'd4; A = 16'h0003; B = 16'h0004; Start = 1'b1;
      tick();
      Start = 1'b0;
      dones = 0; seen = 16'h0000;
      tick();
      Operacioni = 3'd2; A = 16'h0001; B = 16'h0001; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (Done) begin dones++; seen = Rezultati; end
      end
      check("ign_dones", 16'(dones), 16'd1);
      check("ign_res", seen, 16'h0030);

      // Reset in the middle of a shift
      Operacioni = 3'd4; A = 16'h0001; B = 16'h0008; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick(); tick(); tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_rst_res", Rezultati, 16'h0000);
      check("mid_rst_flags", 16'({Zero, Overflow, Busy, Done}), 16'd0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (Done) dones++;
      end
      check("mid_rst_nodone", 16'(dones), 16'd0);
      hold_res = 16'h0000; hold_z = 1'b0; hold_o = 1'b0;
      run_op("post_rst_add", 3'd2, 16'h1234, 16'h0001);

      // randomized ops
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom);
         run_op("rand", rop, 16'($urandom), 16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute stage of the 16-bit datapath. It sits directly downstream of the ALU control decoder and consumes its 3-bit `Operacioni` code together with the two register operands. It then produces the result plus the `Zero` and `Overflow` flags. Logic and arithmetic ops complete in one cycle; shifts use a one-bit-per-cycle iterative shifter to save area. A start/done handshake lets the sequencer stall while a shift is in flight.

## Interface
- `WIDTH`, 16, operand/result width; shift amount is always `B[3:0]`.
- `Clock`  in  1  rising-edge clock, single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request; sampled only when the unit can accept (state IDLE or DONE).
- `Operacioni`  in  3  operation code from the ALU control decoder (see Operation).
- `A`  in  WIDTH  operand A; also the value to be shifted.
- `B`  in  WIDTH  operand B; `B[3:0]` is the shift amount.
- `Rezultati`  out  WIDTH  registered result; holds its value until the next completion.
- `Zero`  out  1  registered; set when the completed result equals 0.
- `Overflow`  out  1  registered; signed overflow for ADD/SUB, 0 for all other ops.
- `Busy`  out  1  high while in state SHIFT.
- `Done`  out  1  one-cycle completion pulse; `Rezultati` and flags are valid while it is high.

## Operation
- Operation codes:
  - 000 AND; 001 OR; 010 ADD; 011 XOR.
  - 100 SLL (logical left shift); 101 SRL (logical right shift).
  - 110 SUB (A-B).
  - 111 SLT: signed A<B gives 16'h0001, otherwise 16'h0000.
- Arithmetic is modulo 2^16.
- ADD overflow: A and B have the same sign and the result sign differs.
- SUB overflow: A and B have different signs and the result sign differs from A.
- FSM states: IDLE, SHIFT, DONE.
- Start accepted in IDLE or DONE, on a non-shift op, or on a shift with `B[3:0]`=0:
  - compute the result combinationally from the inputs;
  - register `Rezultati`, `Zero`, `Overflow` at that edge;
  - go to DONE.
- Start accepted in IDLE or DONE, on a shift with `B[3:0]`=n>0:
  - latch the op, ACC=A, CNT=n;
  - go to SHIFT.
- In SHIFT, each edge: shift ACC by one bit in the latched direction with zero fill, and CNT=CNT-1.
- When CNT reaches 0: write ACC to `Rezultati`, set `Zero`=(ACC==0), `Overflow`=0, and go to DONE.
- Operands and op are latched at acceptance. Changes on `A`, `B` or `Operacioni` during SHIFT have no effect.
- DONE with `Start`=0 returns to IDLE. DONE with `Start`=1 accepts a new request, allowing back-to-back ops.
- `Start` while in SHIFT is ignored. It is not queued.
- `Done` = (state==DONE); `Busy` = (state==SHIFT).

## Timing
- Reset values: state IDLE, `Rezultati`=0, `Zero`=0, `Overflow`=0, `Busy`=0, `Done`=0, ACC=0, CNT=0.
- Reset has priority over `Start` in the same cycle.
- Reset mid-shift aborts the shift. No `Done` pulse follows, and `Rezultati` reads 0.
- Non-shift ops, or shifts with shamt=0, accepted at edge k: `Done`=1 after edge k, so latency is 1 cycle.
- Shift with shamt n>0 accepted at edge k:
  - `Busy`=1 after edges k .. k+n-1;
  - `Done`=1 after edge k+n, so latency is n+1 cycles;
  - worst case is n=15, 16 cycles.
- `Done` lasts exactly one cycle unless a new request accepted in DONE completes immediately. In that case `Done` stays high and `Rezultati` updates each cycle.
- Flags change only at completion edges. They never change during SHIFT.
- Sustained throughput for non-shift ops is one per cycle.

## Test plan
- ADD: `A`=16'h7FFF, `B`=16'h0001, pulse `Start` -> next cycle `Done`=1, `Rezultati`=16'h8000, `Overflow`=1, `Zero`=0.
- SUB and SLT:
  - SUB with `A`=`B`=16'h0005 -> `Rezultati`=0, `Zero`=1, `Overflow`=0.
  - Back-to-back SLT with `A`=16'hFFFF, `B`=16'h0001 on the next cycle -> `Rezultati`=16'h0001 with `Done` held high.
- SLL: `A`=16'h0001, `B`=16'h000F -> `Busy` high for 15 cycles, `Done` on the 16th cycle, `Rezultati`=16'h8000.
  - Changing `A` during SHIFT has no effect.
- SRL: `A`=16'h8000, `B`=16'h0000 -> 1-cycle latency, `Rezultati`=16'h8000.
  - Then SRL with `B`=16'h0004 -> `Rezultati`=16'h0800 after 5 cycles.
- `Start` pulsed during SHIFT is ignored: exactly one `Done` pulse, with the original op's result.
- `Reset` asserted mid-shift (SLL, shamt 8, 3 cycles in):
  - next cycle all outputs are 0 and the state is IDLE;
  - no `Done` pulse follows;
  - the next ADD completes normally.
